// File: rtl/bist_sequencer.sv
// Scan-based BIST session sequencer: seeds LFSR, clears MISR, runs the
// shift/capture rounds, flushes, and compares the final signature.
module bist_sequencer #(
    parameter int                CHAIN_LEN  = 12,
    parameter int                N_PATTERNS = 64,
    parameter int                SIG_W      = 3,
    parameter logic [SIG_W-1:0]  GOLDEN     = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [SIG_W-1:0] sig_in,
    output logic             scan_en,
    output logic             lfsr_seed,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             running,
    output logic             finish,
    output logic             bist_end,
    output logic             pass_fail
);

    localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PW = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST = PW'(N_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [BW-1:0]   r_bit_cnt;
    logic [PW-1:0]   r_pat_cnt;
    logic            r_pass;
    logic            w_active;
    logic            w_abort;
    logic            w_bit_last;
    logic            w_pat_last;

    assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_abort    = ABORT && w_active;
    assign w_bit_last = (r_bit_cnt == BIT_LAST);
    assign w_pat_last = (r_pat_cnt == PAT_LAST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (START && !ABORT) w_next = S_SEED;
                S_SEED:    w_next = S_SHIFT;
                S_SHIFT:   if (w_bit_last) w_next = S_CAPTURE;
                S_CAPTURE: w_next = w_pat_last ? S_FLUSH : S_SHIFT;
                S_FLUSH:   if (w_bit_last) w_next = S_COMPARE;
                S_COMPARE: w_next = S_DONE;
                S_DONE:    if (!START) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // bit_cnt is shared by SHIFT and FLUSH; both leave it at zero on exit
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_bit_cnt <= '0;
            r_pat_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (w_abort) begin
            r_bit_cnt <= '0;
            r_pat_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                S_SEED: begin
                    r_bit_cnt <= '0;
                    r_pat_cnt <= '0;
                    r_pass    <= 1'b0;
                end
                S_SHIFT, S_FLUSH: begin
                    r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    if (!w_pat_last) r_pat_cnt <= r_pat_cnt + 1'b1;
                end
                S_COMPARE: begin
                    r_pass <= (sig_in == GOLDEN);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        scan_en   = 1'b0;
        lfsr_seed = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        running   = 1'b0;
        finish    = 1'b0;
        bist_end  = 1'b0;
        case (r_state)
            S_SEED: begin
                lfsr_seed = 1'b1;
                misr_clr  = 1'b1;
                running   = 1'b1;
            end
            S_SHIFT, S_FLUSH: begin
                scan_en = 1'b1;
                misr_en = 1'b1;
                running = 1'b1;
            end
            S_CAPTURE: begin
                misr_en = 1'b1;
                running = 1'b1;
            end
            S_COMPARE: begin
                finish  = 1'b1;
                running = 1'b1;
            end
            S_DONE: begin
                bist_end = 1'b1;
            end
            default: ;
        endcase
    end

    assign pass_fail = r_pass;

endmodule
